// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: FSM states, handshake levels and a
// helper that turns a possibly negative operand into its magnitude.
package div_iter_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    localparam logic        DivStart          = 1'b1;
    localparam logic        DivStop           = 1'b0;
    localparam logic        DivResultReady    = 1'b1;
    localparam logic        DivResultNotReady = 1'b0;
    localparam logic [31:0] ZeroWord          = 32'h0000_0000;
    localparam int          DivSteps          = 32;

    // Negative values only exist in signed mode; unsigned operands pass through untouched.
    function automatic logic [31:0] magnitude(input logic [31:0] value, input logic is_signed);
        return (is_signed && value[31]) ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative 32/32 restoring divider: one shift-subtract step per clock, optional
// two's-complement handling, result {remainder, quotient} held while start_i stays high.
module div_iter
    import div_iter_pkg::*;
(
    input  logic        rst,
    input  logic        clk,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    div_state_t  state;
    logic [5:0]  cnt;
    logic [64:0] dividend;
    logic [31:0] divisor;
    logic        neg_quot;
    logic        neg_rem;

    logic [64:0] shifted;
    logic [32:0] trial;
    logic [64:0] stepped;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    // dividend[64:32] is the partial remainder, dividend[31:0] collects quotient bits.
    always_comb begin
        shifted  = {dividend[63:0], 1'b0};
        trial    = shifted[64:32] - {1'b0, divisor};
        stepped  = trial[32] ? shifted : {trial, shifted[31:1], 1'b1};
        quot_fix = neg_quot ? (~stepped[31:0] + 32'd1) : stepped[31:0];
        rem_fix  = neg_rem ? (~stepped[63:32] + 32'd1) : stepped[63:32];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= DivFree;
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
        end else begin
            case (state)
                DivFree: begin
                    result_o <= '0;
                    ready_o  <= DivResultNotReady;
                    if (start_i == DivStart && !annul_i) begin
                        cnt      <= '0;
                        dividend <= {33'd0, magnitude(opdata1_i, signed_div_i)};
                        divisor  <= magnitude(opdata2_i, signed_div_i);
                        neg_quot <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                        neg_rem  <= signed_div_i && opdata1_i[31];
                        state    <= (opdata2_i == ZeroWord) ? DivByZero : DivOn;
                    end
                end
                DivByZero: begin
                    dividend <= '0;
                    state    <= DivEnd;
                end
                DivOn: begin
                    if (annul_i || start_i == DivStop) begin
                        state    <= DivFree;
                        cnt      <= '0;
                        result_o <= '0;
                        ready_o  <= DivResultNotReady;
                    end else if (cnt == 6'(DivSteps - 1)) begin
                        // Last step also applies the sign fix-up so DivEnd only has to publish it.
                        dividend <= {1'b0, rem_fix, quot_fix};
                        cnt      <= '0;
                        state    <= DivEnd;
                    end else begin
                        dividend <= stepped;
                        cnt      <= cnt + 6'd1;
                    end
                end
                DivEnd: begin
                    if (start_i == DivStart) begin
                        result_o <= dividend[63:0];
                        ready_o  <= DivResultReady;
                    end else begin
                        state    <= DivFree;
                        result_o <= '0;
                        ready_o  <= DivResultNotReady;
                    end
                end
                default: state <= DivFree;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Randomised scoreboard bench for div_iter: the driver queues expected results, an
// independent monitor pops and compares them whenever ready_o rises.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    div_iter dut (
        .rst          (rst),
        .clk          (clk),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cycle = 0;
    int   n_compared = 0;
    int   n_mismatched = 0;
    logic ready_prev = 1'b0;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, actual, expected);
        end
    endtask

    // Reference: plain 64-bit arithmetic truncates toward zero, so the remainder follows the dividend.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint la, lb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
        end else begin
            la = longint'({32'd0, a});
            lb = longint'({32'd0, b});
        end
        q = la / lb;
        r = la % lb;
        return {r[31:0], q[31:0]};
    endfunction

    // Monitor: any rising ready_o must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (ready_o && !ready_prev) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_ready", 64'(ready_o), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("result", result_o, e.res);
                    checkOutput("latency", 64'(cycle - e.acc), 64'(e.lat));
                end
            end
            if (!ready_o) checkOutput("idle_result_zero", result_o, 64'd0);
        end
        ready_prev = ready_o;
    end

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                 input logic [63:0] exp_res, input string name);
        exp_t e;
        @(negedge clk);
        opdata1_i = a;
        opdata2_i = b;
        signed_div_i = sgn;
        start_i = 1'b1;
        annul_i = 1'b0;
        e.res = exp_res;
        e.lat = (b == 32'd0) ? 2 : 33;
        e.acc = cycle + 1;
        sb.push_back(e);
        for (int w = 0; w < 60; w++) begin
            @(negedge clk);
            #1;
            if (ready_o) break;
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            signed_div_i = 1'($urandom_range(0, 1));
        end
        if (!ready_o) begin
            checkOutput({name, "_ready_timeout"}, 64'(ready_o), 64'd1);
            if (sb.size() > 0) sb.delete(sb.size() - 1);
        end else begin
            repeat (2) begin
                @(negedge clk);
                #1;
                checkOutput({name, "_hold"}, result_o, exp_res);
            end
        end
        start_i = 1'b0;
        @(negedge clk);
        #1;
        checkOutput({name, "_release_ready"}, 64'(ready_o), 64'd0);
        checkOutput({name, "_release_result"}, result_o, 64'd0);
    endtask

    task automatic abortRun(input int iter, input logic use_annul);
        @(negedge clk);
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        signed_div_i = 1'b0;
        start_i = 1'b1;
        annul_i = 1'b0;
        repeat (iter) @(negedge clk);
        if (use_annul) annul_i = 1'b1;
        else start_i = 1'b0;
        @(negedge clk);
        #1;
        checkOutput(use_annul ? "annul_ready" : "stop_ready", 64'(ready_o), 64'd0);
        // start and annul stay high together in DivFree; nothing must be accepted.
        repeat (40) @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        sgn;
        exp_t        e;

        #1;
        checkOutput("reset_ready", 64'(ready_o), 64'd0);
        checkOutput("reset_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, "u100_7");
        applyStimulus(32'hFFFFFFF9, 32'h00000002, 1'b1, 64'hFFFFFFFF_FFFFFFFD, "s_m7_2");
        applyStimulus(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, "s_overflow");
        applyStimulus(32'hFFFFFFFF, 32'h00000010, 1'b0, 64'h0000000F_0FFFFFFF, "u_ffff_16");
        applyStimulus(32'h12345678, 32'h00000000, 1'b1, 64'd0, "div_zero");
        applyStimulus(32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, "s_7_m2");

        abortRun(10, 1'b1);
        abortRun(5, 1'b0);

        // Reset in the middle of an iteration.
        @(negedge clk);
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        signed_div_i = 1'b0;
        start_i = 1'b1;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_mid_ready", 64'(ready_o), 64'd0);
        checkOutput("rst_mid_result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Reset while a result is being held must clear outputs without a clock edge.
        @(negedge clk);
        opdata1_i = 32'hFFFFFFFF;
        opdata2_i = 32'h00000010;
        signed_div_i = 1'b0;
        start_i = 1'b1;
        e.res = 64'h0000000F_0FFFFFFF;
        e.lat = 33;
        e.acc = cycle + 1;
        sb.push_back(e);
        for (int w = 0; w < 60; w++) begin
            @(negedge clk);
            #1;
            if (ready_o) break;
        end
        checkOutput("rst_end_ready_before", 64'(ready_o), 64'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_end_ready", 64'(ready_o), 64'd0);
        checkOutput("rst_end_result", result_o, 64'd0);
        start_i = 1'b0;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, "u100_7_after_rst");

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1, 2:    b = 32'($urandom_range(1, 15));
                3:       b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            sgn = 1'($urandom_range(0, 1));
            applyStimulus(a, b, sgn, ref_div(a, b, sgn), "random");
        end

        repeat (5) @(negedge clk);
        if (sb.size() != 0) checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

endmodule
